// File: rtl/ram_responder_if.sv
// Data-memory bus between the memory controller (master) and the RAM responder (slave).
interface ram_responder_if;
  logic        AddressBusSel;
  logic        RW;
  logic [15:0] AddressBus;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Error;

  modport master (
    output AddressBusSel,
    output RW,
    output AddressBus,
    output DataIn,
    input  DataOut,
    input  Ready,
    input  Error
  );

  modport slave (
    input  AddressBusSel,
    input  RW,
    input  AddressBus,
    input  DataIn,
    output DataOut,
    output Ready,
    output Error
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: captures a controller request, waits a programmable number of
// cycles, performs the word access on internal RAM and answers with a one-cycle Ready pulse.
module ram_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 0
) (
  input logic            clk,
  input logic            rst_n,
  ram_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StRespond, StRelease} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          rw_q;
  logic [15:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   dout_q;
  logic          ready_q;
  logic          error_q;

  logic [31:0]   mem [DEPTH];
  logic          in_range;
  logic          mem_we;
  logic [AW-1:0] mem_idx;

  assign in_range = 32'(addr_q) < DEPTH;
  assign mem_idx  = addr_q[AW-1:0];
  assign mem_we   = (state_q == StAccess) && (cnt_q == 4'd0) && rw_q && in_range;

  // Memory is deliberately not reset; a reset before the commit edge simply never enables it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.AddressBusSel) begin
            addr_q  <= bus.AddressBus;
            wdata_q <= bus.DataIn;
            // Only an explicit 1 selects a write; anything else falls through as a read.
            if (bus.RW) begin
              rw_q  <= 1'b1;
              cnt_q <= 4'(WRITE_WAIT);
            end else begin
              rw_q  <= 1'b0;
              cnt_q <= 4'(READ_WAIT);
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!rw_q) begin
              dout_q <= in_range ? mem[mem_idx] : 32'd0;
            end
            ready_q <= 1'b1;
            error_q <= !in_range;
            state_q <= StRespond;
          end
        end
        StRespond: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= StRelease;
        end
        StRelease: begin
          if (!bus.AddressBusSel) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.Ready   = ready_q;
  assign bus.Error   = error_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: two instances with different wait settings, checked
// against a word-addressed memory model and latency/error rules.
module tb_ram_responder;

  localparam int unsigned DEPTH     = 256;
  localparam int unsigned RD_WAIT_A = 1;
  localparam int unsigned WR_WAIT_A = 0;
  localparam int unsigned RD_WAIT_B = 3;
  localparam int unsigned WR_WAIT_B = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_responder_if bus_a ();
  ram_responder_if bus_b ();

  ram_responder #(
    .DEPTH      (DEPTH),
    .READ_WAIT  (RD_WAIT_A),
    .WRITE_WAIT (WR_WAIT_A)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ram_responder #(
    .DEPTH      (DEPTH),
    .READ_WAIT  (RD_WAIT_B),
    .WRITE_WAIT (WR_WAIT_B)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: written words keyed by instance*65536+address, plus last read value.
  logic [31:0] model_mem [int];
  logic [31:0] model_dout [2];
  int          written_a [$];
  int          written_b [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic sel, input logic rw,
                       input logic [15:0] addr, input logic [31:0] data);
    if (which == 0) begin
      bus_a.AddressBusSel = sel;
      bus_a.RW            = rw;
      bus_a.AddressBus    = addr;
      bus_a.DataIn        = data;
    end else begin
      bus_b.AddressBusSel = sel;
      bus_b.RW            = rw;
      bus_b.AddressBus    = addr;
      bus_b.DataIn        = data;
    end
  endtask

  task automatic sample(input int which, output logic rdy, output logic err,
                        output logic [31:0] dout);
    if (which == 0) begin
      rdy  = bus_a.Ready;
      err  = bus_a.Error;
      dout = bus_a.DataOut;
    end else begin
      rdy  = bus_b.Ready;
      err  = bus_b.Error;
      dout = bus_b.DataOut;
    end
  endtask

  task automatic note_write(input int which, input int addr, input logic [31:0] data);
    model_mem[which * 65536 + addr] = data;
    if (which == 0) written_a.push_back(addr);
    else            written_b.push_back(addr);
  endtask

  // One full transaction; bus inputs are perturbed while the access is in flight.
  task automatic access(input int which, input logic rw, input logic [15:0] addr,
                        input logic [31:0] wdata, input bit early_drop);
    int          w;
    int          cyc;
    logic        exp_err;
    logic        rdy;
    logic        err;
    logic [31:0] dout;
    string       pfx;
    pfx = (which == 0) ? "a." : "b.";
    if (which == 0) w = rw ? int'(WR_WAIT_A) : int'(RD_WAIT_A);
    else            w = rw ? int'(WR_WAIT_B) : int'(RD_WAIT_B);
    exp_err = (int'(addr) >= int'(DEPTH));
    if (rw) begin
      if (!exp_err) note_write(which, int'(addr), wdata);
    end else begin
      model_dout[which] = exp_err ? 32'd0 : model_mem[which * 65536 + int'(addr)];
    end

    drive(which, 1'b1, rw, addr, wdata);
    tick();
    cyc = 0;
    sample(which, rdy, err, dout);
    while (!rdy && cyc < 40) begin
      drive(which, !early_drop, ~rw, addr + 16'd1, ~wdata);
      tick();
      cyc++;
      sample(which, rdy, err, dout);
    end
    check({pfx, "latency"}, 32'(cyc), 32'(w + 1));
    check({pfx, "error"}, {31'd0, err}, {31'd0, exp_err});
    check({pfx, "dataout"}, dout, model_dout[which]);
    tick();
    sample(which, rdy, err, dout);
    check({pfx, "ready_fall"}, {31'd0, rdy}, 32'd0);
    check({pfx, "error_idle"}, {31'd0, err}, 32'd0);
    drive(which, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
  endtask

  task automatic rand_ops(input int which, input int n);
    int          r;
    logic        rw;
    logic [15:0] addr;
    int          sz;
    for (int i = 0; i < n; i++) begin
      r  = int'($urandom_range(0, 7));
      sz = (which == 0) ? written_a.size() : written_b.size();
      rw = (sz == 0) || ($urandom_range(0, 1) == 1);
      if (r == 0)      addr = 16'($urandom_range(DEPTH, 65535));
      else if (r == 7) addr = rw ? 16'(DEPTH - 1) : 16'(DEPTH);
      else if (rw)     addr = 16'($urandom_range(0, DEPTH - 1));
      else if (which == 0) addr = 16'(written_a[$urandom_range(0, sz - 1)]);
      else                 addr = 16'(written_b[$urandom_range(0, sz - 1)]);
      access(which, rw, addr, $urandom, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    logic        rdy;
    logic        err;
    logic [31:0] dout;
    int          pulses;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 32'd0);
    model_dout[0] = 32'd0;
    model_dout[1] = 32'd0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      sample(k, rdy, err, dout);
      check("reset_ready", {31'd0, rdy}, 32'd0);
      check("reset_error", {31'd0, err}, 32'd0);
      check("reset_dataout", dout, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Write/read round trip and out-of-range handling around the DEPTH boundary.
    access(0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 16'h0010, 32'h0, 1'b0);
    access(0, 1'b1, 16'h00FF, 32'hA5A5A5A5, 1'b0);
    access(0, 1'b1, 16'h0100, 32'h12345678, 1'b0);
    access(0, 1'b0, 16'h0100, 32'h0, 1'b0);
    access(0, 1'b0, 16'h00FF, 32'h0, 1'b0);
    access(0, 1'b0, 16'h0010, 32'h0, 1'b1);

    // Held select must yield exactly one access.
    drive(0, 1'b1, 1'b1, 16'h0005, 32'h1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sample(0, rdy, err, dout);
      if (rdy) pulses++;
    end
    check("held_pulses", 32'(pulses), 32'd1);
    note_write(0, 5, 32'h1);
    drive(0, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    access(0, 1'b0, 16'h0005, 32'h0, 1'b0);

    // Inputs swapped to write 0x0003 while read of 0x0002 is in flight.
    access(1, 1'b1, 16'h0002, 32'h22220002, 1'b0);
    access(1, 1'b1, 16'h0003, 32'h33330003, 1'b0);
    access(1, 1'b0, 16'h0002, 32'h0, 1'b0);
    access(1, 1'b0, 16'h0003, 32'h0, 1'b0);

    // Reset two cycles into a write must drop it.
    access(1, 1'b1, 16'h0007, 32'h0, 1'b0);
    access(1, 1'b0, 16'h0002, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b1, 16'h0007, 32'hCAFEF00D);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    sample(1, rdy, err, dout);
    check("rst_mid_ready", {31'd0, rdy}, 32'd0);
    check("rst_mid_dataout", dout, 32'd0);
    model_dout[0] = 32'd0;
    model_dout[1] = 32'd0;
    drive(1, 1'b0, 1'b0, 16'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    access(1, 1'b0, 16'h0007, 32'h0, 1'b0);

    rand_ops(0, 80);
    rand_ops(1, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the CPU's data-memory bus. It receives the address, read/write strobe and write data driven by the memory controller during LDR/STR. It performs the word access on an internal synchronous RAM after a programmable number of wait states, then returns read data with a one-cycle Ready pulse. It sits between the memory controller's bus outputs and its `Din` input, and is the counterpart of the controller's initiator logic.

## Interface
- `DEPTH`, 256: number of 32-bit words; legal word addresses are 0..DEPTH-1 (DEPTH ≤ 65536).
- `READ_WAIT`, 1: extra wait cycles before a read completes (0..15).
- `WRITE_WAIT`, 0: extra wait cycles before a write commits (0..15).

- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `AddressBusSel`  in  1  request valid from controller
- `RW`  in  1  1 = write (STR), 0 = read (LDR)
- `AddressBus`  in  16  word address
- `DataIn`  in  32  write data (controller's `Dout`)
- `DataOut`  out  32  read data (to controller's `Din`)
- `Ready`  out  1  one-cycle completion pulse
- `Error`  out  1  valid only with `Ready`; address ≥ DEPTH

## Operation
- FSM states: IDLE, ACCESS, RESPOND, RELEASE.
- **IDLE**
  - On an edge with `AddressBusSel`=1, latch `AddressBus`, `RW` and `DataIn`.
  - Load the wait counter with WRITE_WAIT if RW=1, else READ_WAIT.
  - Go to ACCESS.
- Capture rule: RW is sampled only at capture. Any RW value other than 1 (X/Z included) is treated as read.
- **ACCESS**
  - Bus inputs are ignored.
  - Counter ≠ 0: decrement it and stay.
  - Counter = 0: perform the access and go to RESPOND.
    - In-range write: `mem[addr] <= data`.
    - In-range read: `DataOut <= mem[addr]`.
    - Out-of-range write: discarded, memory unchanged, error flag set.
    - Out-of-range read: `DataOut <= 0`, error flag set.
- **RESPOND**
  - `Ready`=1 for exactly this cycle; `Error` is the latched flag.
  - Go to RELEASE.
- **RELEASE**
  - Wait for `AddressBusSel`=0, then go to IDLE.
  - A held select never re-issues the same access; each access needs a select low/high transition.
- `DataOut` holds the last read value (including 0 from an error read) until the next read completes. Writes do not change it.
- Dropping `AddressBusSel` during ACCESS does not abort the transaction; it completes and pulses `Ready`. RELEASE then exits on the next edge.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (asserted asynchronously, held while low):
  - State = IDLE, counter = 0.
  - `DataOut`=0, `Ready`=0, `Error`=0.
- Reset mid-operation: the transaction is dropped. A write whose commit edge has not yet occurred is not performed.
- Latency for a request captured at edge N, with W = applicable wait count:
  - Access happens at edge N+1+W.
  - `Ready` is high from edge N+1+W to edge N+2+W.
  - Example: READ_WAIT=1 gives a read captured at edge 0, memory read at edge 2, `Ready` high between edges 2 and 3.
- `Error` is 0 whenever `Ready`=0.
- Minimum spacing between two accesses: the select must be low for ≥1 edge in RELEASE. Throughput is at best one access per W+4 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Write then read (READ_WAIT=1, WRITE_WAIT=0):** write 0xDEADBEEF to address 0x0010, drop select, then read 0x0010.
  - Write: `Ready` 1 cycle after capture.
  - Read: `Ready` 2 cycles after capture with `DataOut`=0xDEADBEEF, `Error`=0.
- **Out of range (DEPTH=256):** write 0x12345678 to 0x0100, then read 0x0100, then read 0x00FF (previously written 0xA5A5A5A5).
  - Write and read of 0x0100: both give `Ready` with `Error`=1; the read gives `DataOut`=0.
  - Read of 0x00FF: `Error`=0, `DataOut`=0xA5A5A5A5, proving memory was not corrupted.
- **Held select:** keep `AddressBusSel`=1 with a write of 0x1 to 0x0005 for 20 cycles → exactly one `Ready` pulse; no second access until select toggles.
- **Inputs change during ACCESS (READ_WAIT=3):** capture a read of 0x0002, then change `AddressBus` to 0x0003 and `RW` to 1 during wait cycles → data of 0x0002 is returned and 0x0003 is unchanged.
- **Reset mid-write (WRITE_WAIT=4):** assert `rst_n`=0 two cycles after capturing a write of 0xCAFEF00D to 0x0007 (0x0007 previously 0x0) → immediate `Ready`=0 and `DataOut`=0; a later read of 0x0007 returns 0x0.
- **Early select drop:** deassert select one cycle after capture of a read → `Ready` still pulses with correct data, and the FSM returns to IDLE one edge later.
